// File: rtl/axis_lane_serializer.sv
// axis_lane_serializer
// AXI4-Stream downsizer: each wide input beat is split into RATIO narrow
// output lanes. Lanes are emitted LSB-first (modes 0/3) or MSB-first
// (mode 1), or one selected lane is emitted per beat (mode 2).
// Mode and lane selection are captured with the beat, so changes to them
// while a beat is being emitted do not affect that beat. A wrapping counter
// tracks completed output frames.
module axis_lane_serializer #(
  parameter int M_WIDTH = 8,
  parameter int RATIO   = 3,
  parameter int LSEL_W  = 2,
  parameter int CNT_W   = 16,
  localparam int S_WIDTH = M_WIDTH * RATIO
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [1:0]         mode,
  input  logic [LSEL_W-1:0]  lane_sel,
  input  logic [S_WIDTH-1:0] s_axis_tdata,
  input  logic               s_axis_tlast,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [M_WIDTH-1:0] m_axis_tdata,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [CNT_W-1:0]   frame_cnt
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  // Lane slots are padded to a power of two so lane_sel-wide indices are
  // always in range of the slot array.
  localparam int NSLOT = 2 ** LSEL_W;

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_SERIAL = 1'b1;

  localparam logic [1:0] MODE_LSB    = 2'd0;
  localparam logic [1:0] MODE_MSB    = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  logic [0:0]         state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [S_WIDTH-1:0] hold_data_reg;
  logic               hold_last_reg;
  logic [1:0]         hold_mode_reg;
  logic [LSEL_W-1:0]  hold_lane_reg;
  logic [CNT_W-1:0]   frame_cnt_reg;

  logic               full;
  logic               last_lane;
  logic               in_hs;
  logic               out_hs;
  logic [LSEL_W-1:0]  lane_pick;
  logic [LSEL_W-1:0]  lane_eff;
  logic [M_WIDTH-1:0] lane_slot [NSLOT];

  assign full = (state_reg == ST_SERIAL);

  // Slice the held beat into lanes; slots beyond RATIO read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < RATIO) begin : g_real
        assign lane_slot[gi] = hold_data_reg[gi*M_WIDTH +: M_WIDTH];
      end else begin : g_pad
        assign lane_slot[gi] = '0;
      end
    end
  endgenerate

  // Single-lane mode emits exactly one lane per beat, so every lane is last.
  assign last_lane = (hold_mode_reg == MODE_SINGLE) ||
                     (idx_reg == IDX_W'(RATIO - 1));

  // Accept a new beat when empty, or when the final lane leaves this cycle.
  assign s_axis_tready = !ap_rst && (!full || (last_lane && m_axis_tready));

  assign in_hs  = s_axis_tvalid && s_axis_tready;
  assign out_hs = full && m_axis_tready;

  // Out-of-range lane selections fall back to lane 0.
  assign lane_eff = (int'(lane_sel) >= RATIO) ? '0 : lane_sel;

  // Choose which lane of the held beat is presented, from the latched mode.
  always_comb begin
    lane_pick = LSEL_W'(idx_reg);
    case (hold_mode_reg)
      MODE_MSB:    lane_pick = LSEL_W'(RATIO - 1) - LSEL_W'(idx_reg);
      MODE_SINGLE: lane_pick = hold_lane_reg;
      default:     lane_pick = LSEL_W'(idx_reg);
    endcase
  end

  assign m_axis_tdata  = lane_slot[lane_pick];
  assign m_axis_tlast  = full && hold_last_reg && last_lane;
  assign m_axis_tvalid = full;
  assign frame_cnt     = frame_cnt_reg;

  // Occupancy FSM and lane counter: load on input handshake, advance on
  // output handshake, return to EMPTY after the final lane with no reload.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_reg <= ST_EMPTY;
      idx_reg   <= '0;
    end else if (in_hs) begin
      state_reg <= ST_SERIAL;
      idx_reg   <= '0;
    end else if (out_hs) begin
      if (last_lane) begin
        state_reg <= ST_EMPTY;
        idx_reg   <= '0;
      end else begin
        idx_reg   <= idx_reg + IDX_W'(1);
      end
    end
  end

  // Hold register: capture the beat with its mode and effective lane.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      hold_data_reg <= '0;
      hold_last_reg <= 1'b0;
      hold_mode_reg <= MODE_LSB;
      hold_lane_reg <= '0;
    end else if (in_hs) begin
      hold_data_reg <= s_axis_tdata;
      hold_last_reg <= s_axis_tlast;
      hold_mode_reg <= mode;
      hold_lane_reg <= lane_eff;
    end
  end

  // Count output frames, one per handshake of a tlast lane; wraps naturally.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      frame_cnt_reg <= '0;
    end else if (out_hs && m_axis_tlast) begin
      frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_lane_serializer.sv
// Testbench for axis_lane_serializer: directed scenarios followed by a
// randomized run, all checked against a queue-based model of the lane
// stream that each accepted beat should produce.
module tb_axis_lane_serializer;

  localparam int M_WIDTH = 8;
  localparam int RATIO   = 3;
  localparam int LSEL_W  = 2;
  localparam int CNT_W   = 16;
  localparam int S_WIDTH = M_WIDTH * RATIO;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b1;
  logic [1:0]         mode = 2'd0;
  logic [LSEL_W-1:0]  lane_sel = '0;
  logic [S_WIDTH-1:0] s_axis_tdata = '0;
  logic               s_axis_tlast = 1'b0;
  logic               s_axis_tvalid = 1'b0;
  logic               s_axis_tready;
  logic [M_WIDTH-1:0] m_axis_tdata;
  logic               m_axis_tlast;
  logic               m_axis_tvalid;
  logic               m_axis_tready = 1'b1;
  logic [CNT_W-1:0]   frame_cnt;

  axis_lane_serializer #(
    .M_WIDTH(M_WIDTH), .RATIO(RATIO), .LSEL_W(LSEL_W), .CNT_W(CNT_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .mode(mode), .lane_sel(lane_sel),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .frame_cnt(frame_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [M_WIDTH-1:0] data;
    logic               last;
  } lane_t;

  lane_t              exp_q[$];
  logic [M_WIDTH-1:0] obs_data[$];
  int                 obs_cyc[$];
  logic [CNT_W-1:0]   exp_frames = '0;
  int                 cyc = 0;
  int                 pass_cnt = 0;
  int                 fail_cnt = 0;
  int                 total_cnt = 0;
  logic               last_in_hs = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected lanes for a beat, derived directly from the mode rules.
  task automatic model_push(input logic [1:0] md, input logic [LSEL_W-1:0] ls,
                            input logic [S_WIDTH-1:0] d, input logic lst);
    lane_t e;
    int    lane;
    if (md == 2'd2) begin
      lane = (int'(ls) >= RATIO) ? 0 : int'(ls);
      e.data = d[lane*M_WIDTH +: M_WIDTH];
      e.last = lst;
      exp_q.push_back(e);
    end else begin
      for (int k = 0; k < RATIO; k++) begin
        lane = (md == 2'd1) ? (RATIO - 1 - k) : k;
        e.data = d[lane*M_WIDTH +: M_WIDTH];
        e.last = lst && (k == RATIO - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // One clock: sample at the falling edge, predict handshakes, advance.
  task automatic tick();
    logic  in_hs;
    logic  out_hs;
    logic  exp_ready;
    lane_t e;
    @(negedge ap_clk);
    in_hs  = s_axis_tvalid && s_axis_tready;
    out_hs = m_axis_tvalid && m_axis_tready;
    check("m_tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && m_axis_tready);
    check("s_tready", 32'(s_axis_tready), 32'(exp_ready));
    if (out_hs && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("m_tdata", 32'(m_axis_tdata), 32'(e.data));
      check("m_tlast", 32'(m_axis_tlast), 32'(e.last));
      obs_data.push_back(m_axis_tdata);
      obs_cyc.push_back(cyc);
      if (e.last) exp_frames = exp_frames + 1'b1;
    end
    if (in_hs) model_push(mode, lane_sel, s_axis_tdata, s_axis_tlast);
    last_in_hs = in_hs;
    @(posedge ap_clk);
    cyc++;
    #1;
    check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
  endtask

  // Present a beat and clock until it is accepted; tvalid stays high.
  task automatic send_beat(input logic [S_WIDTH-1:0] d, input logic lst);
    int n;
    s_axis_tdata  = d;
    s_axis_tlast  = lst;
    s_axis_tvalid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_in_hs && n < 50);
    if (!last_in_hs) check("send_timeout", 32'(n), 32'(0));
  endtask

  task automatic drain();
    int n;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  initial begin
    // Reset state while ap_rst is held.
    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
    check("rst_tdata", 32'(m_axis_tdata), 32'(0));
    check("rst_tlast", 32'(m_axis_tlast), 32'(0));
    check("rst_frame", 32'(frame_cnt), 32'(0));
    check("rst_tready", 32'(s_axis_tready), 32'(0));
    @(posedge ap_clk);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    #1;
    check("post_rst_tready", 32'(s_axis_tready), 32'(1));

    // Mode 0 single beat: CC, BB, AA on consecutive cycles.
    clear_obs();
    mode = 2'd0;
    send_beat(24'hAABBCC, 1'b0);
    drain();
    check("m0_count", 32'(obs_data.size()), 32'(3));
    if (obs_data.size() == 3) begin
      check("m0_lane0", 32'(obs_data[0]), 32'h0CC);
      check("m0_lane1", 32'(obs_data[1]), 32'h0BB);
      check("m0_lane2", 32'(obs_data[2]), 32'h0AA);
      check("m0_span", 32'(obs_cyc[2] - obs_cyc[0]), 32'(2));
    end

    // Mode 1 with tlast: 11, 22, 33 and one completed frame.
    clear_obs();
    mode = 2'd1;
    send_beat(24'h112233, 1'b1);
    drain();
    check("m1_frame", 32'(frame_cnt), 32'(1));
    if (obs_data.size() == 3) begin
      check("m1_lane0", 32'(obs_data[0]), 32'h011);
      check("m1_lane2", 32'(obs_data[2]), 32'h033);
    end else check("m1_count", 32'(obs_data.size()), 32'(3));

    // Mode 2, lane 1, four back-to-back beats, then lane_sel=3 -> lane 0.
    clear_obs();
    mode = 2'd2;
    lane_sel = 2'd1;
    send_beat(24'h0A0B0C, 1'b0);
    send_beat(24'h1A1B1C, 1'b0);
    send_beat(24'h2A2B2C, 1'b0);
    send_beat(24'h3A3B3C, 1'b1);
    lane_sel = 2'd3;
    send_beat(24'h4A4B4C, 1'b0);
    drain();
    check("m2_count", 32'(obs_data.size()), 32'(5));
    if (obs_data.size() == 5) begin
      check("m2_b0", 32'(obs_data[0]), 32'h00B);
      check("m2_b3", 32'(obs_data[3]), 32'h03B);
      check("m2_sel3", 32'(obs_data[4]), 32'h04C);
      check("m2_span", 32'(obs_cyc[3] - obs_cyc[0]), 32'(3));
    end
    lane_sel = 2'd0;

    // Streaming mode 0: 12 lanes with no bubble at beat boundaries.
    clear_obs();
    mode = 2'd0;
    for (int b = 0; b < 4; b++) send_beat(S_WIDTH'($urandom), 1'b0);
    drain();
    check("stream_count", 32'(obs_data.size()), 32'(12));
    if (obs_data.size() == 12)
      check("stream_span", 32'(obs_cyc[11] - obs_cyc[0]), 32'(11));

    // Backpressure on the second lane; mode change must not affect the beat.
    clear_obs();
    mode = 2'd0;
    m_axis_tready = 1'b0;
    send_beat(24'hAABBCC, 1'b0);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    mode = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", 32'(m_axis_tdata), 32'h0BB);
      check("bp_hold_last", 32'(m_axis_tlast), 32'(0));
    end
    drain();
    if (obs_data.size() == 3) begin
      check("bp_lane1", 32'(obs_data[1]), 32'h0BB);
      check("bp_lane2", 32'(obs_data[2]), 32'h0AA);
    end else check("bp_count", 32'(obs_data.size()), 32'(3));

    // Asynchronous reset mid-beat, then a clean beat afterwards.
    mode = 2'd0;
    send_beat(24'h778899, 1'b0);
    s_axis_tvalid = 1'b0;
    tick();
    #2;
    ap_rst = 1'b1;
    #1;
    check("arst_tvalid", 32'(m_axis_tvalid), 32'(0));
    check("arst_frame", 32'(frame_cnt), 32'(0));
    check("arst_tready", 32'(s_axis_tready), 32'(0));
    check("arst_tdata", 32'(m_axis_tdata), 32'(0));
    exp_q.delete();
    exp_frames = '0;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    clear_obs();
    send_beat(24'h445566, 1'b0);
    drain();
    if (obs_data.size() == 3) begin
      check("post_arst_l0", 32'(obs_data[0]), 32'h066);
      check("post_arst_l1", 32'(obs_data[1]), 32'h055);
      check("post_arst_l2", 32'(obs_data[2]), 32'h044);
    end else check("post_arst_count", 32'(obs_data.size()), 32'(3));

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = S_WIDTH'($urandom);
      s_axis_tlast  = ($urandom_range(0, 2) == 0);
      mode          = 2'($urandom);
      lane_sel      = LSEL_W'($urandom);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
